// File: rtl/spipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage scalar core: load-use, multi-cycle EX, dmem wait, redirect.
// Optional performance counters enabled by defining PIPE_PERF_CNT_EN.
module spipeline_ctrl #(
    parameter int unsigned MC_TIMEOUT = 255,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_use_stall,
    input  logic       ex_mc_start,
    input  logic       mc_done,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    input  logic       branch_taken,
    output logic       pc_we,
    output logic       if_id_stall,
    output logic       id_ex_stall,
    output logic       ex_mem_stall,
    output logic       mem_wb_stall,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       mem_wb_flush,
    output logic       mc_timeout,
    output logic [1:0] ctrl_state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events
`endif
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MC_WAIT  = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            w_run_eval;
    logic            w_redirect;

    // State and multi-cycle wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_MC_WAIT) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Next state and per-register stall/flush decode
    always_comb begin
        w_state_nxt  = r_state;
        w_run_eval   = 1'b0;
        w_redirect   = 1'b0;
        pc_we        = 1'b1;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        mc_timeout   = 1'b0;

        unique case (r_state)
            S_RUN: begin
                w_run_eval = 1'b1;
            end
            S_MC_WAIT: begin
                if (mc_done) begin
                    w_state_nxt = S_RUN;
                end else if (r_cnt == CW'(MC_TIMEOUT - 1)) begin
                    mc_timeout   = 1'b1;
                    ex_mem_flush = 1'b1;
                    w_state_nxt  = S_RUN;
                end else begin
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                    pc_we        = 1'b0;
                end
            end
            S_MEM_WAIT: begin
                if (!dmem_ready) begin
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_stall = 1'b1;
                    pc_we        = 1'b0;
                end else begin
                    w_run_eval = 1'b1;
                end
            end
            S_REDIRECT: begin
                if (dmem_req && !dmem_ready) begin
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_stall = 1'b1;
                    pc_we        = 1'b0;
                end else begin
                    if_id_flush = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase

        // Normal issue decision, also taken on the cycle a memory wait resolves
        if (w_run_eval) begin
            w_state_nxt = S_RUN;
            if (dmem_req && !dmem_ready) begin
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_stall = 1'b1;
                pc_we        = 1'b0;
                w_state_nxt  = S_MEM_WAIT;
            end else if (ex_mc_start && !mc_done) begin
                // EX holds the multi-cycle op while MEM receives bubbles
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
                pc_we        = 1'b0;
                w_state_nxt  = S_MC_WAIT;
            end else if (branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                w_redirect  = 1'b1;
                w_state_nxt = S_REDIRECT;
            end else if (load_use_stall) begin
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
                pc_we       = 1'b0;
            end
        end

        if_id_flush  = if_id_flush  & ~if_id_stall;
        id_ex_flush  = id_ex_flush  & ~id_ex_stall;
        ex_mem_flush = ex_mem_flush & ~ex_mem_stall;
        mem_wb_flush = mem_wb_flush & ~mem_wb_stall;

        // Reset holds the whole pipeline in bubbles
        if (!rst_n) begin
            w_redirect   = 1'b0;
            pc_we        = 1'b0;
            if_id_stall  = 1'b0;
            id_ex_stall  = 1'b0;
            ex_mem_stall = 1'b0;
            mem_wb_stall = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            mc_timeout   = 1'b0;
        end
    end

    assign ctrl_state = r_state;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [CNT_WIDTH-1:0] r_flush_events;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!pc_we && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
            if ((w_redirect || mc_timeout) && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_spipeline_ctrl.sv
// Directed self-checking bench for spipeline_ctrl (MC_TIMEOUT=8).
// Observed vector: {pc_we, stalls[if_id..mem_wb], flushes[if_id..mem_wb], mc_timeout, ctrl_state}.
module tb_spipeline_ctrl;

    localparam int unsigned CNT_W = 32;

    logic clk;
    logic rst_n;
    logic load_use_stall, ex_mc_start, mc_done, dmem_req, dmem_ready, branch_taken;
    logic pc_we, mc_timeout;
    logic if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0] ctrl_state;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    spipeline_ctrl #(.MC_TIMEOUT(8), .CNT_WIDTH(CNT_W)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_use_stall (load_use_stall),
        .ex_mc_start    (ex_mc_start),
        .mc_done        (mc_done),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .branch_taken   (branch_taken),
        .pc_we          (pc_we),
        .if_id_stall    (if_id_stall),
        .id_ex_stall    (id_ex_stall),
        .ex_mem_stall   (ex_mem_stall),
        .mem_wb_stall   (mem_wb_stall),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_flush   (ex_mem_flush),
        .mem_wb_flush   (mem_wb_flush),
        .mc_timeout     (mc_timeout),
        .ctrl_state     (ctrl_state)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
`endif
    );

    wire [11:0] w_obs = {pc_we, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                         if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                         mc_timeout, ctrl_state};

    localparam logic [11:0] V_RST    = 12'b0_0000_1111_0_00;
    localparam logic [11:0] V_DEF    = 12'b1_0000_0000_0_00;
    localparam logic [11:0] V_LU     = 12'b0_1000_0100_0_00;
    localparam logic [11:0] V_MC_IN  = 12'b0_1100_0010_0_00;
    localparam logic [11:0] V_MC_W   = 12'b0_1100_0010_0_01;
    localparam logic [11:0] V_MC_DN  = 12'b1_0000_0000_0_01;
    localparam logic [11:0] V_MC_TO  = 12'b1_0000_0010_1_01;
    localparam logic [11:0] V_MEM_IN = 12'b0_1111_0000_0_00;
    localparam logic [11:0] V_MEM_W  = 12'b0_1111_0000_0_10;
    localparam logic [11:0] V_MEM_BR = 12'b1_0000_1100_0_10;
    localparam logic [11:0] V_BR     = 12'b1_0000_1100_0_00;
    localparam logic [11:0] V_RDIR   = 12'b1_0000_1000_0_11;
    localparam logic [11:0] V_RD_MEM = 12'b0_1111_0000_0_11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic lu, input logic mcs, input logic mcd,
                         input logic dreq, input logic drdy, input logic br);
        load_use_stall = lu;
        ex_mc_start    = mcs;
        mc_done        = mcd;
        dmem_req       = dreq;
        dmem_ready     = drdy;
        branch_taken   = br;
    endtask

    // Check the current cycle's outputs, then advance to just after the next edge
    task automatic cyc(input string tag, input logic [11:0] exp);
        #1;
        check(tag, 32'(w_obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        check("reset", 32'(w_obs), 32'(V_RST));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc("idle", V_DEF);
        drive(1, 0, 0, 0, 0, 0); cyc("load_use", V_LU);
        drive(0, 0, 0, 0, 0, 0); cyc("after_lu", V_DEF);

        // Multi-cycle op completing five cycles after start
        drive(0, 1, 0, 0, 0, 0); cyc("mc_entry", V_MC_IN);
        for (int i = 0; i < 4; i++) cyc("mc_wait", V_MC_W);
        drive(0, 1, 1, 0, 0, 0); cyc("mc_done", V_MC_DN);
        drive(0, 0, 0, 0, 0, 0); cyc("mc_back_run", V_DEF);

        // Timeout: no mc_done, branch/load-use ignored while frozen
        drive(0, 1, 0, 0, 0, 0); cyc("to_entry", V_MC_IN);
        drive(1, 1, 0, 0, 0, 1); cyc("to_ignore_br_lu", V_MC_W);
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc("to_wait", V_MC_W);
        cyc("to_pulse", V_MC_TO);
        drive(0, 0, 0, 0, 0, 0); cyc("to_after", V_DEF);

        drive(0, 1, 1, 0, 0, 0); cyc("mc_same_cycle", V_DEF);
        drive(0, 0, 0, 0, 0, 0); cyc("mc_same_after", V_DEF);

        // Memory wait beats a pending redirect, redirect follows on ready
        drive(0, 0, 0, 1, 0, 1); cyc("mem_entry", V_MEM_IN);
        cyc("mem_wait1", V_MEM_W);
        cyc("mem_wait2", V_MEM_W);
        drive(0, 0, 0, 1, 1, 1); cyc("mem_ready_br", V_MEM_BR);
        drive(0, 0, 0, 0, 0, 0); cyc("mem_redirect", V_RDIR);
        cyc("mem_after", V_DEF);

        drive(1, 0, 0, 0, 0, 1); cyc("br_and_lu", V_BR);
        drive(0, 0, 0, 0, 0, 0); cyc("br_redirect", V_RDIR);
        cyc("br_after", V_DEF);

        // Memory wait while in REDIRECT holds the redirect
        drive(0, 0, 0, 0, 0, 1); cyc("rd_br", V_BR);
        drive(0, 0, 0, 1, 0, 0); cyc("rd_mem_stall", V_RD_MEM);
        drive(0, 0, 0, 1, 1, 0); cyc("rd_mem_ready", V_RDIR);
        drive(0, 0, 0, 0, 0, 0); cyc("rd_after", V_DEF);

        // Asynchronous reset in the middle of a multi-cycle wait
        drive(0, 1, 0, 0, 0, 0); cyc("ar_entry", V_MC_IN);
        #1;
        check("ar_pre", 32'(w_obs), 32'(V_MC_W));
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_async", 32'(w_obs), 32'(V_RST));
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("ar_release", V_DEF);

        drive(1, 0, 0, 0, 0, 0); cyc("pf_lu", V_LU);
        drive(1, 0, 0, 0, 0, 1); cyc("pf_br_lu", V_BR);
        drive(0, 0, 0, 0, 0, 0); cyc("pf_redirect", V_RDIR);
`ifdef PIPE_PERF_CNT_EN
        check("perf_stall_cycles", stall_cycles, 32'd1);
        check("perf_flush_events", flush_events, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
